wm_seq_gen: RTL and testbench

WM_SEQ_GEN -- requirements
Module: wm_seq_gen

---
 rtl/wm_pkg.sv | 29 ++
 rtl/wm_lfsr_step.sv | 21 ++
 rtl/wm_seq_gen.sv | 104 ++++++++++
 tb/tb_wm_seq_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wm_pkg.sv
// Shared types and constants for the watermark sequence generator.
// FSM state type, symbol-mapping encodings, default taps/seed and the symbol mapper.
package wm_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } wm_state_e;

  localparam int unsigned SYM_RAW     = 0;
  localparam int unsigned SYM_TERNARY = 1;

  // x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [7:0] DEFAULT_TAPS = 8'h1D;
  localparam logic [7:0] DEFAULT_KEY  = 8'h6A;

  // Ternary mode never produces 2'b11, so the symbol alphabet is {00, 01, 10}.
  function automatic logic [1:0] map_sym(input logic [1:0] s, input int unsigned mode);
    logic hi;
    logic lo;
    if (mode == SYM_RAW) begin
      return s;
    end
    hi = s[1] ^ s[0];
    lo = hi ? 1'b0 : s[0];
    return {hi, lo};
  endfunction

endpackage

// File: rtl/wm_lfsr_step.sv
// Combinational next-state function of the de Bruijn-extended Galois LFSR.
// The all-zero state is spliced into the cycle, giving a full 2^LFSR_W period.
module wm_lfsr_step #(
  parameter int unsigned         LFSR_W = 8,
  parameter logic [LFSR_W-1:0]   TAPS   = LFSR_W'(8'h1D)
) (
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  logic low_zero;
  logic fb;

  always_comb begin
    low_zero = (cur[LFSR_W-2:0] == '0);
    // Feedback is inverted when the low bits are zero: 0x80 -> 0x00 -> TAPS.
    fb  = cur[LFSR_W-1] ^ low_zero;
    nxt = {cur[LFSR_W-2:0], 1'b0} ^ (fb ? TAPS : '0);
  end

endmodule

// File: rtl/wm_seq_gen.sv
// Watermark symbol sequence generator with valid/ready handshake and runtime reseed.
// Define WM_PERIOD_CNT_EN to build the period counter and period_done pulse.
module wm_seq_gen
  import wm_pkg::*;
#(
  parameter int unsigned       LFSR_W   = 8,
  parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] KEY      = LFSR_W'(DEFAULT_KEY),
  parameter int unsigned       SYM_MODE = SYM_TERNARY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              key_load,
  input  logic [LFSR_W-1:0] key_in,
  input  logic              sym_ready,
  output logic              sym_valid,
  output logic [1:0]        sym_data,
  output logic              period_done
);

  wm_state_e         fsm_q;
  logic              sym_valid_q;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_next;
  logic              handshake;

  wm_lfsr_step #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS)
  ) u_step (
    .cur (lfsr_q),
    .nxt (lfsr_next)
  );

  assign handshake = sym_valid_q & sym_ready;

  // key_load wins over handshake and enable; a coincident handshake symbol is
  // treated as consumed, but the seed overwrites the stepped value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q      <= KEY;
      fsm_q       <= IDLE;
      sym_valid_q <= 1'b0;
    end else if (key_load) begin
      lfsr_q      <= key_in;
      fsm_q       <= IDLE;
      sym_valid_q <= 1'b0;
    end else begin
      if (handshake) begin
        lfsr_q <= lfsr_next;
      end
      unique case (fsm_q)
        IDLE: begin
          if (en) begin
            fsm_q       <= RUN;
            sym_valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (!en) begin
            fsm_q       <= IDLE;
            sym_valid_q <= 1'b0;
          end
        end
        default: begin
          fsm_q       <= IDLE;
          sym_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_data  = map_sym(lfsr_q[1:0], SYM_MODE);

`ifdef WM_PERIOD_CNT_EN
  localparam logic [LFSR_W:0] CNT_LAST = {1'b0, {LFSR_W{1'b1}}};
  localparam logic [LFSR_W:0] CNT_ONE  = {{LFSR_W{1'b0}}, 1'b1};

  logic [LFSR_W:0] cnt_q;
  logic            done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (key_load) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= handshake && (cnt_q == CNT_LAST);
      if (handshake) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
      end
    end
  end

  assign period_done = done_q;
`else
  assign period_done = 1'b0;
`endif

endmodule

// File: tb/tb_wm_seq_gen.sv
// Directed self-checking bench for wm_seq_gen with default parameters.
module tb_wm_seq_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       key_load;
  logic [7:0] key_in;
  logic       sym_ready;
  logic       sym_valid;
  logic [1:0] sym_data;
  logic       period_done;

  int checks = 0;
  int errors = 0;

`ifdef WM_PERIOD_CNT_EN
  localparam int EXP_DONE = 1;
`else
  localparam int EXP_DONE = 0;
`endif

  wm_seq_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .key_load    (key_load),
    .key_in      (key_in),
    .sym_ready   (sym_ready),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .period_done (period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; key_load = 1'b0; key_in = 8'h00; sym_ready = 1'b0;
    tick();
    tick();
    if (sym_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", sym_valid);
    end
    checks++;
    if (sym_data !== 2'b10) begin
      errors++; $display("FAIL reset_data got %b want 10", sym_data);
    end
    checks++;
    if (dut.lfsr_q !== 8'h6A) begin
      errors++; $display("FAIL reset_state got %h want 6a", dut.lfsr_q);
    end
    checks++;
    if (period_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", period_done);
    end
    checks++;
    rst = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0] exp_s [3];
    logic [1:0] exp_d [3];
    exp_s[0] = 8'h6A; exp_d[0] = 2'b10;
    exp_s[1] = 8'hD4; exp_d[1] = 2'b00;
    exp_s[2] = 8'hB5; exp_d[2] = 2'b10;
    en = 1'b1; sym_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (sym_valid !== 1'b1 || dut.lfsr_q !== exp_s[i] || sym_data !== exp_d[i]) begin
        errors++;
        $display("FAIL stream_%0d got v=%b s=%h d=%b want v=1 s=%h d=%b",
                 i, sym_valid, dut.lfsr_q, sym_data, exp_s[i], exp_d[i]);
      end
      checks++;
      if (i < 2) tick();
    end
    sym_ready = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (sym_valid !== 1'b1 || dut.lfsr_q !== 8'hB5 || sym_data !== 2'b10) begin
        errors++;
        $display("FAIL stall_%0d got v=%b s=%h d=%b want v=1 s=b5 d=10",
                 i, sym_valid, dut.lfsr_q, sym_data);
      end
      checks++;
    end
  endtask

  task automatic test_abort();
    en = 1'b0;
    tick();
    if (sym_valid !== 1'b0 || dut.lfsr_q !== 8'hB5) begin
      errors++;
      $display("FAIL abort got v=%b s=%h want v=0 s=b5", sym_valid, dut.lfsr_q);
    end
    checks++;
    en = 1'b1;
    tick();
    if (sym_valid !== 1'b1 || dut.lfsr_q !== 8'hB5) begin
      errors++;
      $display("FAIL resume got v=%b s=%h want v=1 s=b5", sym_valid, dut.lfsr_q);
    end
    checks++;
  endtask

  task automatic test_zero_transition();
    key_load = 1'b1; key_in = 8'h80; sym_ready = 1'b0;
    tick();
    key_load = 1'b0;
    if (sym_valid !== 1'b0 || dut.lfsr_q !== 8'h80) begin
      errors++;
      $display("FAIL load80 got v=%b s=%h want v=0 s=80", sym_valid, dut.lfsr_q);
    end
    checks++;
    sym_ready = 1'b1;
    tick();
    if (sym_valid !== 1'b1 || dut.lfsr_q !== 8'h80 || sym_data !== 2'b00) begin
      errors++;
      $display("FAIL run80 got v=%b s=%h d=%b want v=1 s=80 d=00",
               sym_valid, dut.lfsr_q, sym_data);
    end
    checks++;
    tick();
    if (dut.lfsr_q !== 8'h00) begin
      errors++; $display("FAIL step80 got %h want 00", dut.lfsr_q);
    end
    checks++;
    tick();
    if (dut.lfsr_q !== 8'h1D) begin
      errors++; $display("FAIL step00 got %h want 1d", dut.lfsr_q);
    end
    checks++;
    sym_ready = 1'b0;
  endtask

  task automatic test_period();
    logic [255:0] seen;
    int           distinct;
    int           done_cnt;
    int           done_at;
    seen = '0; distinct = 0; done_cnt = 0; done_at = 0;
    key_load = 1'b1; key_in = 8'h6A; sym_ready = 1'b0;
    tick();
    key_load = 1'b0;
    tick();
    sym_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      if (!seen[dut.lfsr_q]) distinct++;
      seen[dut.lfsr_q] = 1'b1;
      tick();
      if (period_done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
    end
    sym_ready = 1'b0;
    if (dut.lfsr_q !== 8'h6A) begin
      errors++; $display("FAIL period_state got %h want 6a", dut.lfsr_q);
    end
    checks++;
    if (distinct !== 256) begin
      errors++; $display("FAIL period_distinct got %0d want 256", distinct);
    end
    checks++;
    if (done_cnt !== EXP_DONE || done_at !== EXP_DONE * 256) begin
      errors++;
      $display("FAIL period_done_pulse got cnt=%0d at=%0d want cnt=%0d at=%0d",
               done_cnt, done_at, EXP_DONE, EXP_DONE * 256);
    end
    checks++;
    tick();
    if (period_done !== 1'b0) begin
      errors++; $display("FAIL period_done_drop got %b want 0", period_done);
    end
    checks++;
  endtask

  task automatic test_key_zero();
    sym_ready = 1'b1;
    en = 1'b1;
    // Seed load coincides with a live handshake.
    key_load = 1'b1; key_in = 8'h00;
    tick();
    key_load = 1'b0;
    if (sym_valid !== 1'b0 || dut.lfsr_q !== 8'h00) begin
      errors++;
      $display("FAIL key0_load got v=%b s=%h want v=0 s=00", sym_valid, dut.lfsr_q);
    end
    checks++;
    tick();
    if (sym_valid !== 1'b1 || sym_data !== 2'b00 || dut.lfsr_q !== 8'h00) begin
      errors++;
      $display("FAIL key0_restart got v=%b s=%h d=%b want v=1 s=00 d=00",
               sym_valid, dut.lfsr_q, sym_data);
    end
    checks++;
    tick();
    if (dut.lfsr_q !== 8'h1D || sym_data !== 2'b10) begin
      errors++;
      $display("FAIL key0_step got s=%h d=%b want s=1d d=10", dut.lfsr_q, sym_data);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    if (sym_valid !== 1'b1) begin
      errors++; $display("FAIL arst_pre got v=%b want 1", sym_valid);
    end
    checks++;
    #2;
    rst = 1'b1;
    #1;
    if (sym_valid !== 1'b0 || dut.lfsr_q !== 8'h6A || sym_data !== 2'b10) begin
      errors++;
      $display("FAIL arst got v=%b s=%h d=%b want v=0 s=6a d=10",
               sym_valid, dut.lfsr_q, sym_data);
    end
    checks++;
    tick();
    rst = 1'b0;
    tick();
    if (sym_valid !== 1'b1 || dut.lfsr_q !== 8'h6A) begin
      errors++;
      $display("FAIL arst_restart got v=%b s=%h want v=1 s=6a", sym_valid, dut.lfsr_q);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_abort();
    test_zero_transition();
    test_period();
    test_key_zero();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
